// File: rtl/pipelined_cpu_pkg.sv
// Shared constants, instruction field layout and pipeline register types
// for the pipelined_cpu4 core.
package pipelined_cpu_pkg;
    localparam int DATA_W     = 32;
    localparam int NREGS      = 8;
    localparam int IMEM_DEPTH = 16;
    localparam int DMEM_DEPTH = 16;
    localparam int REG_AW     = $clog2(NREGS);
    localparam int PC_W       = $clog2(IMEM_DEPTH);
    localparam int DMEM_AW    = $clog2(DMEM_DEPTH);
    localparam int INSTR_W    = 16;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_LOAD = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;

    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 6;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [3:0]        op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] imm;
    } id_ex_t;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] result;
    } ex_wb_t;

    // lo6 is either {rs2, 3'b000} or a 6-bit immediate.
    function automatic logic [INSTR_W-1:0] encode(input logic [3:0] op,
                                                  input logic [REG_AW-1:0] rd,
                                                  input logic [REG_AW-1:0] rs1,
                                                  input logic [5:0] lo6);
        return {op, rd, rs1, lo6};
    endfunction

    localparam logic [INSTR_W*IMEM_DEPTH-1:0] DEFAULT_PROGRAM = {
        {(IMEM_DEPTH-5){16'h0000}},
        encode(OP_LOAD, 3'd5, 3'd0, 6'd2),
        encode(OP_SUB,  3'd4, 3'd1, {3'd2, 3'd0}),
        encode(OP_ADD,  3'd3, 3'd1, {3'd2, 3'd0}),
        encode(OP_ADDI, 3'd2, 3'd0, 6'd3),
        encode(OP_ADDI, 3'd1, 3'd0, 6'd5)
    };
endpackage

// File: rtl/cpu_regfile.sv
// Register file: two asynchronous read ports, one write port, write-through
// bypass so a same-cycle read sees the value being written; r0 reads as zero.
module cpu_regfile
    import pipelined_cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we && waddr != '0) begin
            regs_d[waddr] = wdata;
        end
    end

    // Reading the next-state view gives the write-through behaviour for free.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) rdata1 = regs_d[raddr1];
        if (raddr2 != '0) rdata2 = regs_d[raddr2];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end
endmodule

// File: rtl/pipelined_cpu4.sv
// Four-stage in-order CPU (IF -> ID -> EX -> WB) with its own ROM, read-only
// data memory and register file; EX forwards from EX/WB, ID reads write-through.
module pipelined_cpu4
    import pipelined_cpu_pkg::*;
#(
    parameter logic [INSTR_W*IMEM_DEPTH-1:0] PROGRAM = DEFAULT_PROGRAM
) (
    input logic clk,
    input logic reset
);
    logic [PC_W-1:0] pc_q, pc_d;
    if_id_t          if_id_q, if_id_d;
    id_ex_t          id_ex_q, id_ex_d;
    ex_wb_t          ex_wb_q, ex_wb_d;

    logic [PC_W-1:0]   pc;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_result;
    logic              wb_we;

    assign pc        = pc_q;
    assign wb_rd     = ex_wb_q.rd;
    assign wb_result = ex_wb_q.result;
    assign wb_we     = ex_wb_q.we;

    logic [INSTR_W-1:0] rom [IMEM_DEPTH];
    for (genvar i = 0; i < IMEM_DEPTH; i++) begin : g_rom
        assign rom[i] = PROGRAM[INSTR_W*i +: INSTR_W];
    end

    function automatic logic is_exec_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LOAD) || (op == OP_ADDI);
    endfunction

    // Data memory is never written, so each word is simply its reset image.
    function automatic logic [DATA_W-1:0] dmem_word(input logic [DMEM_AW-1:0] addr);
        return DATA_W'(addr) + DATA_W'(16);
    endfunction

    // IF
    always_comb begin
        if_id_d.instr = rom[pc];
        pc_d = (pc_q == PC_W'(IMEM_DEPTH-1)) ? '0 : pc_q + 1'b1;
    end

    // ID
    logic [INSTR_W-1:0] instr;
    logic [REG_AW-1:0]  rs1_addr, rs2_addr;
    logic [DATA_W-1:0]  rs1_data, rs2_data;

    assign instr    = if_id_q.instr;
    assign rs1_addr = instr[RS1_LSB +: REG_AW];
    assign rs2_addr = instr[RS2_LSB +: REG_AW];

    always_comb begin
        id_ex_d.op  = is_exec_op(instr[OP_LSB +: 4]) ? instr[OP_LSB +: 4] : OP_NOP;
        id_ex_d.rd  = instr[RD_LSB +: REG_AW];
        id_ex_d.rs1 = rs1_addr;
        id_ex_d.rs2 = rs2_addr;
        id_ex_d.a   = rs1_data;
        id_ex_d.b   = rs2_data;
        id_ex_d.imm = {{(DATA_W-IMM_W){instr[IMM_LSB+IMM_W-1]}}, instr[IMM_LSB +: IMM_W]};
    end

    // EX
    logic signed [DATA_W-1:0] op_a, op_b, addr_sum;

    always_comb begin
        op_a = id_ex_q.a;
        op_b = id_ex_q.b;
        if (ex_wb_q.we && ex_wb_q.rd != '0 && ex_wb_q.rd == id_ex_q.rs1) op_a = ex_wb_q.result;
        if (ex_wb_q.we && ex_wb_q.rd != '0 && ex_wb_q.rd == id_ex_q.rs2) op_b = ex_wb_q.result;
        addr_sum = op_a + $signed(id_ex_q.imm);

        ex_wb_d.we = (id_ex_q.op != OP_NOP) && (id_ex_q.rd != '0);
        ex_wb_d.rd = id_ex_q.rd;
        case (id_ex_q.op)
            OP_ADD:  ex_wb_d.result = op_a + op_b;
            OP_SUB:  ex_wb_d.result = op_a - op_b;
            OP_LOAD: ex_wb_d.result = dmem_word(addr_sum[DMEM_AW-1:0]);
            OP_ADDI: ex_wb_d.result = addr_sum;
            default: ex_wb_d.result = '0;
        endcase
    end

    // WB
    cpu_regfile u_regfile (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (rs1_addr),
        .rdata1 (rs1_data),
        .raddr2 (rs2_addr),
        .rdata2 (rs2_data),
        .we     (wb_we),
        .waddr  (wb_rd),
        .wdata  (wb_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= '0;
            if_id_q <= '0;
            id_ex_q <= '0;
            ex_wb_q <= '0;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
            id_ex_q <= id_ex_d;
            ex_wb_q <= ex_wb_d;
        end
    end
endmodule

// File: tb/tb_pipelined_cpu4.sv
// Bench for pipelined_cpu4: fixed-program commit sequences plus a pseudo-random
// program under randomly timed asynchronous resets, checked against an ISA-level model.
module tb_pipelined_cpu4;
    import pipelined_cpu_pkg::*;

    localparam logic [255:0] OVR_PROG = {
        {12{16'h0000}},
        encode(OP_ADD,  3'd1, 3'd0, {3'd0, 3'd0}),
        encode(OP_ADDI, 3'd0, 3'd0, 6'd7),
        encode(OP_ADD,  3'd2, 3'd1, {3'd1, 3'd0}),
        encode(OP_ADDI, 3'd1, 3'd0, 6'h3F)
    };

    function automatic logic [255:0] gen_prog(input logic [31:0] seed);
        logic [31:0]  s;
        logic [255:0] p;
        logic [3:0]   op;
        s = seed;
        p = '0;
        for (int i = 0; i < 16; i++) begin
            s = s ^ (s << 13);
            s = s ^ (s >> 17);
            s = s ^ (s << 5);
            op = (s[2:0] < 3'd5) ? {1'b0, s[2:0]} : (s[3] ? OP_ADDI : s[31:28]);
            p[16*i +: 16] = {op, s[14:12], s[11:9], s[20:15]};
        end
        return p;
    endfunction

    localparam logic [255:0] RAND_PROG = gen_prog(32'hC0FFEE11);

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_o = 1'b1;
    logic rst_r = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipelined_cpu4 dut_a (.clk(clk), .reset(rst_a));
    pipelined_cpu4 dut_b (.clk(clk), .reset(rst_b));
    pipelined_cpu4 #(.PROGRAM(OVR_PROG))  dut_o (.clk(clk), .reset(rst_o));
    pipelined_cpu4 #(.PROGRAM(RAND_PROG)) dut_r (.clk(clk), .reset(rst_r));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %08h expected %08h", tag, $time, got, exp);
        end
    endtask

    // ISA-level model: executes the program strictly in order on plain arrays.
    logic [255:0] rand_prog = RAND_PROG;
    logic [31:0]  mregs [8];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mregs[i] = 32'd0;
    endtask

    task automatic model_exec(input int k, output logic we, output logic [2:0] rd,
                              output logic [31:0] res);
        logic [15:0] w;
        logic [31:0] a, b, imm;
        w   = rand_prog[16*k +: 16];
        rd  = w[11:9];
        a   = mregs[w[8:6]];
        b   = mregs[w[5:3]];
        imm = {{26{w[5]}}, w[5:0]};
        we  = 1'b1;
        res = 32'd0;
        case (w[15:12])
            4'd1:    res = a + b;
            4'd2:    res = a - b;
            4'd3:    res = ((a + imm) % 16) + 16;
            4'd4:    res = a + imm;
            default: we = 1'b0;
        endcase
        if (rd == 3'd0) we = 1'b0;
        if (we) mregs[rd] = res;
    endtask

    int          exp_rd  [5] = '{1, 2, 3, 4, 5};
    logic [31:0] exp_res [5] = '{32'h5, 32'h3, 32'h8, 32'h2, 32'h12};

    initial begin
        fork
            begin : thr_a
                int k;
                #2;
                check("a_rst_pc", dut_a.pc, 0);
                check("a_rst_we", dut_a.wb_we, 0);
                check("a_rst_rd", dut_a.wb_rd, 0);
                check("a_rst_res", dut_a.wb_result, 0);
                check("o_rst_we", dut_o.wb_we, 0);
                #8;
                rst_a = 1'b0;
                rst_o = 1'b0;
                for (int n = 1; n <= 22; n++) begin
                    #10;
                    check("a_pc", dut_a.pc, n % 16);
                    if (n < 3) begin
                        check("a_we_fill", dut_a.wb_we, 0);
                    end else begin
                        k = (n - 3) % 16;
                        if (k < 5) begin
                            check("a_we", dut_a.wb_we, 1);
                            check("a_rd", dut_a.wb_rd, exp_rd[k]);
                            check("a_res", dut_a.wb_result, exp_res[k]);
                        end else begin
                            check("a_we_nop", dut_a.wb_we, 0);
                        end
                    end
                end
            end
            begin : thr_b
                #10 rst_b = 1'b0;
                #40;
                check("b_pc_pre", dut_b.pc, 4);
                check("b_we_pre", dut_b.wb_we, 1);
                #2 rst_b = 1'b1;
                #1;
                check("b_pc_async", dut_b.pc, 0);
                check("b_we_async", dut_b.wb_we, 0);
                check("b_rd_async", dut_b.wb_rd, 0);
                #4 rst_b = 1'b0;
                #3;
                check("b_pc_60", dut_b.pc, 0);
                #10;
                check("b_pc_70", dut_b.pc, 1);
                check("b_we_70", dut_b.wb_we, 0);
                #10;
                check("b_we_80", dut_b.wb_we, 0);
                #10;
                check("b_pc_90", dut_b.pc, 3);
                check("b_we_90", dut_b.wb_we, 1);
                check("b_rd_90", dut_b.wb_rd, 1);
                check("b_res_90", dut_b.wb_result, 32'h5);
                #10;
                check("b_rd_100", dut_b.wb_rd, 2);
                check("b_res_100", dut_b.wb_result, 32'h3);
            end
            begin : thr_o
                #40;
                check("o_we_0", dut_o.wb_we, 1);
                check("o_rd_0", dut_o.wb_rd, 1);
                check("o_res_0", dut_o.wb_result, 32'hFFFFFFFF);
                #10;
                check("o_we_1", dut_o.wb_we, 1);
                check("o_rd_1", dut_o.wb_rd, 2);
                check("o_res_1", dut_o.wb_result, 32'hFFFFFFFE);
                #10;
                check("o_we_r0", dut_o.wb_we, 0);
                #10;
                check("o_we_3", dut_o.wb_we, 1);
                check("o_rd_3", dut_o.wb_rd, 1);
                check("o_res_3", dut_o.wb_result, 32'h0);
                #10;
                check("o_we_nop", dut_o.wb_we, 0);
            end
            begin : thr_r
                int          n, cycles;
                logic        m_we;
                logic [2:0]  m_rd;
                logic [31:0] m_res;
                #2;
                check("r_rst_pc", dut_r.pc, 0);
                check("r_rst_we", dut_r.wb_we, 0);
                #8 rst_r = 1'b0;
                #1;
                for (int ep = 0; ep < 6; ep++) begin
                    model_reset();
                    n = 0;
                    cycles = $urandom_range(20, 50);
                    repeat (cycles) begin
                        @(posedge clk);
                        #1;
                        n++;
                        check("r_pc", dut_r.pc, n % 16);
                        if (n < 3) begin
                            check("r_we_fill", dut_r.wb_we, 0);
                        end else begin
                            model_exec((n - 3) % 16, m_we, m_rd, m_res);
                            check("r_we", dut_r.wb_we, m_we);
                            if (m_we) begin
                                check("r_rd", dut_r.wb_rd, m_rd);
                                check("r_res", dut_r.wb_result, m_res);
                            end
                        end
                    end
                    #($urandom_range(1, 7));
                    rst_r = 1'b1;
                    #1;
                    check("r_pc_async", dut_r.pc, 0);
                    check("r_we_async", dut_r.wb_we, 0);
                    check("r_rd_async", dut_r.wb_rd, 0);
                    check("r_res_async", dut_r.wb_result, 0);
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #($urandom_range(2, 8));
                    rst_r = 1'b0;
                end
            end
        join
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
